// File: rtl/pc_ctrl_if.sv
// Redirect/hold request from ex plus the fetch-side handshake, grouped between
// pc_ctrl (slave) and the surrounding pipeline (master).
interface pc_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        ifetch_ready_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        stall_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_flag_i, ifetch_ready_i,
    input  pc_o, pc_valid_o, flush_o, stall_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_flag_i, ifetch_ready_i,
    output pc_o, pc_valid_o, flush_o, stall_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program counter owner: applies ex redirects/holds, produces if_id/id_ex flush
// and stall, parks a redirect while instruction memory is busy, counts events.
module pc_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  pc_ctrl_if.slave         bus,
  output logic             misalign_o,
  output logic [CNT_W-1:0] jump_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [31:0]      pc_r, pc_nxt_s;
  logic [31:0]      pending_r, pending_nxt_s;
  logic             misalign_r;
  logic [CNT_W-1:0] jump_cnt_r, stall_cnt_r;
  logic [31:0]      target_s;
  logic             jump_acc_s;
  logic             flush_s, stall_s, pc_valid_s;

  assign target_s = {bus.jump_addr_i[31:2], 2'b00};

  // Next-state, next-pc and pipeline control decode
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    pending_nxt_s = pending_r;
    flush_s       = 1'b0;
    stall_s       = 1'b0;
    pc_valid_s    = 1'b0;
    jump_acc_s    = 1'b0;
    case (state_r)
      BOOT: begin
        flush_s     = 1'b1;
        state_nxt_s = RUN;
      end
      RUN: begin
        pc_valid_s = 1'b1;
        if (bus.jump_en_i) begin
          flush_s    = 1'b1;
          jump_acc_s = 1'b1;
          if (bus.ifetch_ready_i) begin
            pc_nxt_s = target_s;
          end else begin
            pending_nxt_s = target_s;
            state_nxt_s   = REDIRECT;
          end
        end else if (bus.hold_flag_i || !bus.ifetch_ready_i) begin
          stall_s = 1'b1;
        end else begin
          pc_nxt_s = pc_r + 32'd4;
        end
      end
      REDIRECT: begin
        // pc stays on the stale address the memory is still working on
        pc_valid_s = 1'b1;
        flush_s    = 1'b1;
        if (bus.jump_en_i) begin
          jump_acc_s    = 1'b1;
          pending_nxt_s = target_s;
          if (bus.ifetch_ready_i) begin
            pc_nxt_s    = target_s;
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = REDIRECT;
          end
        end else if (bus.ifetch_ready_i) begin
          pc_nxt_s    = pending_r;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = REDIRECT;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // State, pc, pending target and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= BOOT;
      pc_r        <= RESET_ADDR;
      pending_r   <= 32'h0000_0000;
      misalign_r  <= 1'b0;
      jump_cnt_r  <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      pending_r  <= pending_nxt_s;
      misalign_r <= jump_acc_s & (|bus.jump_addr_i[1:0]);
      if (jump_acc_s) begin
        jump_cnt_r <= jump_cnt_r + CNT_W'(1);
      end else begin
        jump_cnt_r <= jump_cnt_r;
      end
      if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.pc_o       = pc_r;
  assign bus.pc_valid_o = pc_valid_s;
  assign bus.flush_o    = flush_s;
  assign bus.stall_o    = stall_s;
  assign misalign_o     = misalign_r;
  assign jump_cnt_o     = jump_cnt_r;
  assign stall_cnt_o    = stall_cnt_r;

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Control end of the execute-stage redirect/hold interface: consumes jump_en/jump_addr/hold_flag from ex.
- Owns the program counter and drives it to instruction fetch.
- Produces flush and stall controls for if_id and id_ex.
- Tracks a fetch-side handshake so a redirect survives a busy instruction memory; keeps wrapping jump/stall event counters for debug.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of jump_cnt_o / stall_cnt_o

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
jump_en_i  input  1  ex requests redirect this cycle
jump_addr_i  input  32  redirect target from ex
hold_flag_i  input  1  ex requests pipeline hold this cycle
ifetch_ready_i  input  1  instruction memory accepts the fetch at pc_o this cycle
pc_o  output  32  current fetch address
pc_valid_o  output  1  pc_o is a valid fetch request
flush_o  output  1  if_id and id_ex load NOP at next edge
stall_o  output  1  if_id and id_ex hold contents at next edge
misalign_o  output  1  one-cycle pulse: accepted jump target had nonzero bits [1:0]
jump_cnt_o  output  CNT_W  number of accepted redirects, wraps
stall_cnt_o  output  CNT_W  number of cycles with stall_o=1, wraps

Behaviour:
- States: BOOT, RUN, REDIRECT. Encoding is free.
- Reset values, on the clk edge with rst=1:
  - state=BOOT, pc_o=RESET_ADDR, pending target=0, misalign_o=0, counters=0.
  - rst overrides all other inputs, including mid-REDIRECT.
- BOOT (exactly 1 cycle):
  - pc_valid_o=0, flush_o=1, stall_o=0, pc_o held.
  - Always -> RUN.
- RUN (pc_valid_o=1); priority is jump > hold > fetch-not-ready:
  - jump_en_i=1:
    - flush_o=1, stall_o=0 (combinational, same cycle).
    - Target T={jump_addr_i[31:2],2'b00}; misalign_o<=|jump_addr_i[1:0]; jump_cnt_o++.
    - If ifetch_ready_i=1: pc_o<=T, stay RUN.
    - Else: pending<=T, pc_o unchanged, -> REDIRECT.
    - hold_flag_i is ignored in that cycle.
  - else hold_flag_i=1: stall_o=1, flush_o=0, pc_o held.
  - else ifetch_ready_i=0: stall_o=1, flush_o=0, pc_o held.
  - else: pc_o<=pc_o+4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- REDIRECT (pc_valid_o=1):
  - pc_o still shows the stale address the memory is busy with; flush_o=1 every cycle; stall_o=0.
  - ifetch_ready_i=1: pc_o<=pending, -> RUN.
  - A new jump_en_i in this state: pending<=new T, misalign_o and jump_cnt_o update as in RUN; the last target wins.
  - If the new jump coincides with ifetch_ready_i=1: pc_o<=new T, -> RUN.
  - hold_flag_i is ignored in REDIRECT.
- Output rules:
  - flush_o and stall_o are never both 1.
  - stall_cnt_o increments on each cycle with stall_o=1.
  - misalign_o is 0 in any cycle without an accepted jump.
- Latency:
  - Redirect visible on pc_o one edge after jump_en_i when memory is ready.
  - Otherwise visible one edge after the first ifetch_ready_i=1.

Test Plan:
- Reset release, RESET_ADDR=0, ifetch_ready_i=1, no jump/hold -> one BOOT cycle (pc_valid_o=0, flush_o=1); then pc_o=0,4,8,C on consecutive cycles; counters 0.
- At pc_o=0x10, jump_en_i=1, jump_addr_i=0x100 for 1 cycle -> flush_o=1 same cycle; next cycle pc_o=0x100; jump_cnt_o=1; misalign_o=0.
- hold_flag_i=1 for 3 cycles at pc_o=0x20 -> stall_o=1 for 3 cycles; pc_o stays 0x20; stall_cnt_o=3; then pc_o=0x24.
- jump_en_i and hold_flag_i both 1, jump_addr_i=0x203 -> flush_o=1, stall_o=0; next pc_o=0x200; misalign_o pulses 1.
- ifetch_ready_i=0 during jump to 0x300, then jump to 0x400 while still not ready, ready after 2 more cycles:
  - flush_o held 1 through REDIRECT; pc_o stale until ready.
  - Then pc_o=0x400; jump_cnt_o=2.
- rst=1 asserted while in REDIRECT -> next cycle BOOT with pc_o=RESET_ADDR; pending target discarded; counters 0.
- pc_o=0xFFFF_FFFC, ifetch_ready_i=1 -> next pc_o=0x0.
